vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 16 +
 rtl/vram_arbiter_if.sv | 41 ++++
 rtl/vram_starve_ctr.sv | 31 +++
 rtl/vram_arbiter.sv | 80 ++++++++
 tb/tb_vram_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared types and default widths for the VRAM arbiter slice.
package vram_pkg;

  localparam int ADDR_W_DEF     = 14;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;

  // Type of the access issued on the previous cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VID_RD = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } issue_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Request/grant/completion and RAM-side signals of the VRAM arbiter.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vid_gnt, vid_rvalid, vid_rdata, cpu_gnt, cpu_done, cpu_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_gnt, vid_rvalid, vid_rdata, cpu_gnt, cpu_done, cpu_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vram_starve_ctr.sv
// Counts consecutive video wins while the CPU waits; starved flags that the CPU
// must win the next contended cycle. Registered, updates every cycle, no stall.
module vram_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_core,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic vid_gnt,
  input  logic cpu_gnt,
  output logic starved
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      cnt <= '0;
    end else if (vid_gnt && (cnt != MAX_CNT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign starved = (cnt == MAX_CNT);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: zero-latency grant, one access per cycle, read data
// and completions one cycle after grant; requesters wait (req held) until granted.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic           clk_core,
  input  logic           reset_n,
  vram_arbiter_if.slave  bus
);

  issue_state_t      state;
  logic              vid_gnt;
  logic              cpu_gnt;
  logic              cpu_win;
  logic              starved;
  logic              vid_rvalid_q;
  logic              cpu_done_q;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] rdata_vid;
  logic [DATA_W-1:0] rdata_cpu;

  vram_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .cpu_req  (bus.cpu_req),
    .vid_gnt  (vid_gnt),
    .cpu_gnt  (cpu_gnt),
    .starved  (starved)
  );

  // Grants are gated by reset_n so nothing issues while reset is held.
  always_comb begin
    cpu_win  = bus.cpu_req & (~bus.vid_req | starved);
    vid_gnt  = reset_n & bus.vid_req & ~cpu_win;
    cpu_gnt  = reset_n & bus.cpu_req & cpu_win;
    addr_sel = cpu_gnt ? bus.cpu_addr : bus.vid_addr;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      vid_rvalid_q <= 1'b0;
      cpu_done_q   <= 1'b0;
    end else begin
      if (cpu_gnt) begin
        state <= bus.cpu_we ? CPU_WR : CPU_RD;
      end else if (vid_gnt) begin
        state <= VID_RD;
      end else begin
        state <= IDLE;
      end
      vid_rvalid_q <= vid_gnt;
      cpu_done_q   <= cpu_gnt;
    end
  end

  // Read data is forced to zero outside its owner's read cycle.
  always_comb begin
    rdata_vid = (state == VID_RD) ? bus.mem_rdata : '0;
    rdata_cpu = (state == CPU_RD) ? bus.mem_rdata : '0;
  end

  assign bus.vid_gnt    = vid_gnt;
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.vid_rdata  = rdata_vid;
  assign bus.cpu_done   = cpu_done_q;
  assign bus.cpu_rdata  = rdata_cpu;
  assign bus.mem_en     = vid_gnt | cpu_gnt;
  assign bus.mem_we     = cpu_gnt & bus.cpu_we;
  assign bus.mem_addr   = addr_sel;
  assign bus.mem_wdata  = bus.cpu_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic clk_core;
  logic reset_n;

  vram_arbiter_if #(.ADDR_W(14), .DATA_W(16)) bus ();

  vram_arbiter #(.ADDR_W(14), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  logic [15:0] ram [0:16383];
  always @(posedge clk_core) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    byte         g;
    logic        we;
    logic [13:0] addr;
  } gexp_t;

  typedef struct {
    logic        rd;
    logic [15:0] d;
  } cexp_t;

  gexp_t       gnt_q [$];
  logic [15:0] vid_q [$];
  cexp_t       cpu_q [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the expected grant and completion for it.
  task automatic step(input logic vr, input logic [13:0] va, input logic cr, input logic cw,
                      input logic [13:0] ca, input logic [15:0] cwd, input byte g,
                      input logic [15:0] exp_d, input bit push_d);
    gexp_t e;
    cexp_t c;
    @(posedge clk_core);
    #1;
    bus.vid_req   = vr;
    bus.vid_addr  = va;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cwd;
    e.g    = g;
    e.we   = (g == "C") ? cw : 1'b0;
    e.addr = (g == "C") ? ca : va;
    gnt_q.push_back(e);
    if (push_d && g == "V") vid_q.push_back(exp_d);
    if (push_d && g == "C") begin
      c.rd = ~cw;
      c.d  = exp_d;
      cpu_q.push_back(c);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 16'h0, "-", 16'h0, 1'b0);
  endtask

  // Monitor: compares every cycle against the queued expectations.
  initial begin : monitor
    bit    prev_v;
    bit    prev_c;
    gexp_t e;
    cexp_t c;
    logic [15:0] vd;
    prev_v = 1'b0;
    prev_c = 1'b0;
    forever begin
      @(negedge clk_core);
      e.g = "-"; e.we = 1'b0; e.addr = 14'h0;
      if (gnt_q.size() > 0) e = gnt_q.pop_front();
      chk("vid_gnt", 32'(bus.vid_gnt), 32'(e.g == "V"));
      chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(e.g == "C"));
      chk("mem_en",  32'(bus.mem_en),  32'(e.g != "-"));
      chk("mem_we",  32'(bus.mem_we),  32'(e.we));
      if (e.g != "-") chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
      chk("vid_rvalid", 32'(bus.vid_rvalid), 32'(prev_v & reset_n));
      chk("cpu_done",   32'(bus.cpu_done),   32'(prev_c & reset_n));
      if (bus.vid_rvalid) begin
        if (vid_q.size() == 0) begin
          chk("vid_unexpected", 32'(1), 32'(0));
        end else begin
          vd = vid_q.pop_front();
          chk("vid_rdata", 32'(bus.vid_rdata), 32'(vd));
        end
      end else begin
        chk("vid_rdata_zero", 32'(bus.vid_rdata), 32'(0));
      end
      if (bus.cpu_done) begin
        if (cpu_q.size() == 0) begin
          chk("cpu_unexpected", 32'(1), 32'(0));
        end else begin
          c = cpu_q.pop_front();
          if (c.rd) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(c.d));
        end
      end else begin
        chk("cpu_rdata_zero", 32'(bus.cpu_rdata), 32'(0));
      end
      if (!reset_n) begin
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_starve", 32'(dut.u_starve.cnt), 32'(0));
      end
      prev_v = (e.g == "V");
      prev_c = (e.g == "C");
    end
  end

  initial begin : stim
    string       seq;
    int          vi;
    logic [15:0] vtab [8];
    for (int i = 0; i < 16384; i++) ram[i] = 16'(i) ^ 16'hA5A5;
    vtab = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6, 16'hA5A1, 16'hA5A0, 16'hA5A3, 16'hA5A2};

    // Reset held with both requesters active: nothing may issue.
    reset_n       = 1'b0;
    bus.vid_req   = 1'b1;
    bus.vid_addr  = 14'h1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 14'h2;
    bus.cpu_wdata = 16'hDEAD;
    repeat (3) @(posedge clk_core);
    #1;
    reset_n     = 1'b1;
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;

    idle(10);

    for (int i = 0; i < 8; i++)
      step(1'b1, 14'(i), 1'b0, 1'b0, 14'h0, 16'h0, "V", vtab[i], 1'b1);
    idle(1);

    // Contention: video addresses advance only on video grants.
    seq = "VVVVCVVVVC";
    vi  = 0;
    for (int i = 0; i < 10; i++) begin
      if (seq[i] == "V") begin
        step(1'b1, 14'(14'h100 + vi), 1'b1, 1'b0, 14'h010, 16'h0, "V", 16'hA4A5 ^ 16'(vi), 1'b1);
        vi++;
      end else begin
        step(1'b1, 14'(14'h100 + vi), 1'b1, 1'b0, 14'h010, 16'h0, "C", 16'hA5B5, 1'b1);
      end
    end
    idle(1);

    step(1'b0, 14'h0, 1'b1, 1'b1, 14'h3FFF, 16'h1234, "C", 16'h0, 1'b1);
    step(1'b0, 14'h0, 1'b1, 1'b0, 14'h3FFF, 16'h0, "C", 16'h1234, 1'b1);
    idle(1);

    // CPU drops its request on the 4th cycle, restarting the fairness count.
    for (int j = 0; j < 8; j++)
      step(1'b1, 14'(14'h200 + j), (j == 3) ? 1'b0 : 1'b1, 1'b0, 14'h010, 16'h0,
           "V", 16'hA7A5 ^ 16'(j), 1'b1);
    step(1'b1, 14'h208, 1'b1, 1'b0, 14'h010, 16'h0, "C", 16'hA5B5, 1'b1);
    idle(1);

    // Reset in the cycle after a video grant: its completion must vanish.
    step(1'b1, 14'h5, 1'b0, 1'b0, 14'h0, 16'h0, "V", 16'h0, 1'b0);
    @(posedge clk_core);
    #1;
    reset_n     = 1'b0;
    bus.vid_req = 1'b0;
    gnt_q.push_back('{"-", 1'b0, 14'h0});
    @(posedge clk_core);
    #1;
    chk("state_after_release", 32'(dut.state), 32'(IDLE));
    reset_n      = 1'b1;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h3;
    gnt_q.push_back('{"V", 1'b0, 14'h3});
    vid_q.push_back(16'hA5A6);
    idle(3);

    @(posedge clk_core);
    #2;
    chk("gnt_q_drained", 32'(gnt_q.size()), 32'(0));
    chk("vid_q_drained", 32'(vid_q.size()), 32'(0));
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
